// File: rtl/seq_det_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_det_pkg: shared state type, pattern and defaults for seq_det blocks   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package seq_det_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_CNT_W  = 4;

  // Serial pattern recognised by seq_det, in arrival order.
  localparam logic [3:0] SEQ_PATTERN = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_det.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_det: Mealy detector for the serial pattern 1010, overlapping matches  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module seq_det (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic out
);

  typedef enum logic [1:0] {
    S_NONE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_101  = 2'd3
  } det_state_t;

  det_state_t state;

  // After a match the trailing "10" is kept so overlapping matches count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_NONE;
    end else begin
      case (state)
        S_NONE:  state <= x ? S_1   : S_NONE;
        S_1:     state <= x ? S_1   : S_10;
        S_10:    state <= x ? S_101 : S_NONE;
        S_101:   state <= x ? S_1   : S_10;
        default: state <= S_NONE;
      endcase
    end
  end

  assign out = (state == S_101) && !x;

endmodule
`default_nettype wire

// File: rtl/seq_det_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_det_frame_ctrl: word handshake wrapper serialising words into seq_det |
// | Rev 1.0; SEQ_DET_CTRL_LSB_FIRST_EN selects LSB-first serialisation        |
// +--------------------------------------------------------------------------+
module seq_det_frame_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_hit,
  output logic              busy
);

  localparam int               BIT_W    = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ctrl_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  count_next;
  logic              serial_bit;
  logic              det_x;
  logic              det_out;

`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
  assign serial_bit = shreg[0];
  assign shreg_next = {1'b0, shreg[DATA_W-1:1]};
`else
  assign serial_bit = shreg[DATA_W-1];
  assign shreg_next = {shreg[DATA_W-2:0], 1'b0};
`endif

  // busy mirrors ST_SHIFT, so the detector only ever sees zeros outside a word.
  assign det_x      = busy & serial_bit;
  assign count_next = (det_out && (out_count != CNT_MAX)) ? out_count + 1'b1 : out_count;

  seq_det u_det (
    .clk (clk),
    .rst (rst),
    .x   (det_x),
    .out (det_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      out_count <= '0;
      out_hit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg     <= in_data;
            bit_cnt   <= '0;
            out_count <= '0;
            out_hit   <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg     <= shreg_next;
          bit_cnt   <= bit_cnt + 1'b1;
          out_count <= count_next;
          out_hit   <= (count_next != '0);
          if (bit_cnt == LAST_BIT) begin
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_det_frame_ctrl: vector table, corner sequences and random words    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_seq_det_frame_ctrl;
  import seq_det_pkg::*;

  localparam int DATA_W = DEFAULT_DATA_W;
  localparam int CNT_W  = DEFAULT_CNT_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_hit;
  logic              busy;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              hit;
  } vec_t;

  vec_t vecs[7];

  seq_det_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_hit   (out_hit),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Slide a 4-bit window over the serial bit stream and count pattern hits.
  function automatic int ref_count(input logic [DATA_W-1:0] w);
    logic bits [DATA_W];
    int   c;
    c = 0;
    for (int i = 0; i < DATA_W; i++) begin
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
      bits[i] = w[i];
`else
      bits[i] = w[DATA_W-1-i];
`endif
    end
    for (int i = 0; i + 3 < DATA_W; i++)
      if ({bits[i], bits[i+1], bits[i+2], bits[i+3]} == SEQ_PATTERN) c++;
    if (c > (2**CNT_W - 1)) c = 2**CNT_W - 1;
    return c;
  endfunction

  // Entered and left at a negedge; hold = cycles out_ready stays low in DONE.
  task automatic do_word(input logic [DATA_W-1:0] d, input int hold,
                         output int acc_edge, output logic [CNT_W-1:0] cnt,
                         output logic hit);
    bit ok;
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (in_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("accept_wait", ok, 1);
    acc_edge = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    @(negedge clk);
    check("busy_in_shift", busy, 1);
    check("in_ready_in_shift", in_ready, 0);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    check("done_wait", ok, 1);
    check("latency", cyc - acc_edge, DATA_W);
    check("busy_in_done", busy, 0);
    cnt = out_count;
    hit = out_hit;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_out_count", out_count, cnt);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("released_out_valid", out_valid, 0);
    check("released_in_ready", in_ready, 1);
  endtask

  initial begin
    int               acc1, acc2, exp;
    logic [CNT_W-1:0] c1, c2;
    logic             h1, h2;
    int               seen;
    logic [DATA_W-1:0] w;

`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
    vecs[0] = '{8'hAA, 4'd2, 1'b1};
    vecs[1] = '{8'h00, 4'd0, 1'b0};
    vecs[2] = '{8'h0A, 4'd1, 1'b1};
    vecs[3] = '{8'hA0, 4'd0, 1'b0};
    vecs[4] = '{8'h55, 4'd3, 1'b1};
    vecs[5] = '{8'hFF, 4'd0, 1'b0};
    vecs[6] = '{8'h5A, 4'd1, 1'b1};
`else
    vecs[0] = '{8'hAA, 4'd3, 1'b1};
    vecs[1] = '{8'h00, 4'd0, 1'b0};
    vecs[2] = '{8'h0A, 4'd1, 1'b1};
    vecs[3] = '{8'hA0, 4'd1, 1'b1};
    vecs[4] = '{8'h55, 4'd2, 1'b1};
    vecs[5] = '{8'hFF, 4'd0, 1'b0};
    vecs[6] = '{8'h5A, 4'd1, 1'b1};
`endif

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_count", out_count, 0);
    check("reset_out_hit", out_hit, 0);
    check("reset_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      do_word(vecs[i].data, 0, acc1, c1, h1);
      check($sformatf("vec%0d_count", i), c1, vecs[i].cnt);
      check($sformatf("vec%0d_hit", i), h1, vecs[i].hit);
    end

    // Back-to-back words whose junction would form 1010.
    do_word(8'h01, 0, acc1, c1, h1);
    do_word(8'h40, 0, acc2, c2, h2);
    check("b2b_count_first", c1, 0);
    check("b2b_count_second", c2, 0);
    check("b2b_spacing", acc2 - acc1, DATA_W + 2);

    do_word(8'hAA, 5, acc1, c1, h1);
    check("hold_count", c1, ref_count(8'hAA));
    check("hold_hit", h1, 1);

    // Reset in the 4th SHIFT cycle aborts the word.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_count", out_count, 0);
    check("abort_out_hit", out_hit, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("abort_no_result", seen, 0);
    do_word(8'h0A, 0, acc1, c1, h1);
    check("after_abort_count", c1, 1);

    for (int i = 0; i < 40; i++) begin
      w = DATA_W'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_word(w, $urandom_range(0, 3), acc1, c1, h1);
      exp = ref_count(w);
      check($sformatf("rand%0d_count_%02h", i, w), c1, exp);
      check($sformatf("rand%0d_hit_%02h", i, w), h1, exp != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_frame_ctrl.md
# seq_det_frame_ctrl

Word-level controller for the serial `1010` detector `seq_det`. It accepts parallel words over a valid/ready handshake and shifts each word bit-serially into the detector, one bit per clock. It counts the detector's match pulses and returns one match count per word over a second valid/ready handshake. It sits between a parallel producer and the bit-serial detector, so the detector can be used on word streams.

## Interface
- `DATA_W`, 8 — bits per input word; must be ≥4
- `CNT_W`, 4 — width of the match count; the count saturates at 2^CNT_W−1
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — input word valid
- `in_ready` output 1 — controller can accept a word; high only in IDLE
- `in_data` input DATA_W — word to scan
- `out_valid` output 1 — result valid; high only in DONE
- `out_ready` input 1 — consumer accepts the result
- `out_count` output CNT_W — number of `1010` matches in the word; overlapping matches count
- `out_hit` output 1 — `out_count != 0`
- `busy` output 1 — high in SHIFT

## Operation
- FSM states:
  - **IDLE**: `in_ready=1`. When `in_valid && in_ready`, load `in_data` into the shift register, clear the bit counter and match counter, and go to SHIFT.
  - **SHIFT**: drive detector `x` from the current serial bit. On each edge, shift the register, increment the bit counter, and add 1 to the match counter if the detector output is 1. When the bit counter reaches DATA_W−1, go to DONE.
  - **DONE**: hold `out_valid=1` and the `out_count` and `out_hit` values. When `out_ready` is high, go to IDLE.
- Bit order without the macro: MSB first.
- Outside SHIFT, detector `x` is driven to 0 and the detector output is ignored.
- DONE and IDLE together last at least 2 cycles, so the detector sees at least two zeros between words and is back in its initial state before the next word. Each word is scanned independently: a pattern spanning two words never counts.
- The match counter saturates at its maximum and never wraps.
- `in_data` is captured only on the accepting edge; later changes have no effect.
- `in_valid` while not in IDLE: ignored, and the word stays pending at the producer.
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `out_count=0`, `out_hit=0`, `busy=0`, detector `x=0`, shift register 0.
- Reset asserted mid-SHIFT or mid-DONE aborts the word with no result. The detector is reset by the same `rst`.

## Timing
- Word accepted at edge k → SHIFT occupies cycles k+1 … k+DATA_W → `out_valid` goes high in cycle k+DATA_W+1.
- `out_valid` stays high until the edge where `out_ready=1`. The next cycle is IDLE.
- Minimum spacing between accepted words: DATA_W+2 cycles (SHIFT, 1 DONE, 1 IDLE).
- Detector output is Mealy (combinational on `x`). The controller samples it on the same edge that advances the bit.
- `in_ready` and `out_valid` are decoded from state only and never depend combinationally on `in_valid`/`out_ready`.

## Configuration
- `SEQ_DET_CTRL_LSB_FIRST_EN`:
  - Defined: words are serialized LSB first (register shifts right and `x` is bit 0).
  - Undefined: MSB first (register shifts left and `x` is bit DATA_W−1).
- All timing and the handshake are identical in both cases.

## Structure
- A shared package `seq_det_pkg` holds:
  - the FSM state typedef (IDLE, SHIFT, DONE);
  - the detected pattern constant `4'b1010`, for documentation and bench reference models;
  - the default DATA_W and CNT_W values.
- One sub-module: an instance of the existing `seq_det`, with `clk`, `rst`, `x` from the shift register, and `out` feeding the match counter.
- The shift register, bit counter, match counter and FSM live in `seq_det_frame_ctrl`.

## Test plan
- Reset, then 0xAA with `out_ready=1` → `out_valid` at cycle k+9, `out_count=3`, `out_hit=1`.
- 0x00 → `out_count=0`, `out_hit=0`. 0x0A → `out_count=1`.
- Word 0x01, then 0x40, sent back-to-back → counts 0 and 0; the cross-word `1010` is not counted. Check the accept-to-accept spacing is 10 cycles.
- 0xAA with `out_ready` held low for 5 cycles → `out_valid`, `out_count=3` and `in_ready=0` stable throughout. Result accepted on the first edge with `out_ready=1`, then IDLE.
- Reset pulsed in the 4th SHIFT cycle of 0xAA → all outputs return to reset values and no result is produced. A following 0x0A gives `out_count=1`.
- 0xA0: without the macro → `out_count=1`; with `SEQ_DET_CTRL_LSB_FIRST_EN` → `out_count=0`.
